// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: CP0 register numbers, exception-type codes shared with ctrl,
// Status/Cause bit positions and a small ExcCode helper.
// Optional feature macro used by this slice: CP0_TIMER_EN.
package cp0_reg_pkg;

   // CP0 register numbers (rd field of mtc0/mfc0)
   localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_REG_EPC     = 5'd14;
   localparam logic [4:0] CP0_REG_PRID    = 5'd15;
   localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

   // Exception-type codes as produced by MEM and consumed by ctrl
   localparam logic [31:0] EXC_INT          = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
   localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
   localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
   localparam logic [31:0] EXC_OV           = 32'h0000_000c;
   localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

   // Status / Cause bit positions
   localparam int STATUS_EXL   = 1;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_IV     = 23;
   localparam int CAUSE_WP     = 22;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_SW_HI  = 9;
   localparam int CAUSE_SW_LO  = 8;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_EXC_LO = 2;

   // ExcCode field values written into Cause[6:2]
   typedef enum logic [4:0] {
      EXCCODE_INT  = 5'h00,
      EXCCODE_SYS  = 5'h08,
      EXCCODE_RI   = 5'h0a,
      EXCCODE_OV   = 5'h0c,
      EXCCODE_TRAP = 5'h0d
   } exccode_e;

   // Map a recordable exception type onto its ExcCode
   function automatic exccode_e exccode_of(input logic [31:0] exc);
      exccode_e c;
      c = EXCCODE_INT;
      case (exc)
         EXC_SYSCALL:      c = EXCCODE_SYS;
         EXC_INST_INVALID: c = EXCCODE_RI;
         EXC_TRAP:         c = EXCCODE_TRAP;
         EXC_OV:           c = EXCCODE_OV;
         default:          c = EXCCODE_INT;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// cp0_reg_if: mtc0/mfc0 access and MEM-stage exception report into CP0.
// master = pipeline side, slave = CP0.
interface cp0_reg_if;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;

   modport master (
      output we_i, waddr_i, data_i, raddr_i,
      output excepttype_i, current_inst_addr_i, is_in_delayslot_i,
      input  data_o
   );

   modport slave (
      input  we_i, waddr_i, data_i, raddr_i,
      input  excepttype_i, current_inst_addr_i, is_in_delayslot_i,
      output data_o
   );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer interrupt.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   // Count wraps naturally; an mtc0 load replaces the increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          count <= '0;
      else if (count_we) count <= wdata;
      else               count <= count + 32'd1;
   end

   // Compare is software-only state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            compare <= '0;
      else if (compare_we) compare <= wdata;
   end

   // Sticky match flag; a Compare write clears it even on a matching cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    timer_int <= 1'b0;
      else if (compare_we)                         timer_int <= 1'b0;
      else if (compare != '0 && count == compare)  timer_int <= 1'b1;
   end

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file (Count, Compare, Status, Cause, EPC, PRId,
// Config) with precise exception recording and the timer interrupt.
// Optional feature macro: CP0_TIMER_EN (Count/Compare/timer present).
module cp0_reg
   import cp0_reg_pkg::*;
#(
   parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
   parameter logic [31:0] CONFIG_RESET = 32'h00008000,
   parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
   input  logic        clk,
   input  logic        rst,
   cp0_reg_if.slave    bus,
   input  logic [5:0]  int_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   logic [31:0] status, cause, epc;
   logic        exc_vld;
   logic        wr_ok;
   logic [31:0] rec_epc;

   // Any reported exception squashes a concurrent mtc0
   assign exc_vld = |bus.excepttype_i;
   assign wr_ok   = bus.we_i && !exc_vld;
   assign rec_epc = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                          : bus.current_inst_addr_i;

`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_ok && bus.waddr_i == CP0_REG_COUNT),
      .compare_we (wr_ok && bus.waddr_i == CP0_REG_COMPARE),
      .wdata      (bus.data_i),
      .count      (count_o),
      .compare    (compare_o),
      .timer_int  (timer_int_o)
   );
`else
   assign count_o     = '0;
   assign compare_o   = '0;
   assign timer_int_o = 1'b0;
`endif

   // Status/Cause/EPC update: exceptions first, otherwise mtc0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status <= STATUS_RESET;
         cause  <= '0;
         epc    <= '0;
      end else begin
         cause[CAUSE_IP_HI:CAUSE_IP_LO] <= int_i;
         if (exc_vld) begin
            case (bus.excepttype_i)
               EXC_INT: begin
                  epc                              <= rec_epc;
                  cause[CAUSE_BD]                  <= bus.is_in_delayslot_i;
                  status[STATUS_EXL]               <= 1'b1;
                  cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= EXCCODE_INT;
               end
               EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV: begin
                  // nested exceptions keep the original return point
                  if (!status[STATUS_EXL]) begin
                     epc             <= rec_epc;
                     cause[CAUSE_BD] <= bus.is_in_delayslot_i;
                  end
                  status[STATUS_EXL]               <= 1'b1;
                  cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exccode_of(bus.excepttype_i);
               end
               EXC_ERET: status[STATUS_EXL] <= 1'b0;
               default: ;
            endcase
         end else if (wr_ok) begin
            case (bus.waddr_i)
               CP0_REG_STATUS: status <= bus.data_i;
               CP0_REG_EPC:    epc    <= bus.data_i;
               CP0_REG_CAUSE: begin
                  cause[CAUSE_IV]                <= bus.data_i[CAUSE_IV];
                  cause[CAUSE_WP]                <= bus.data_i[CAUSE_WP];
                  cause[CAUSE_SW_HI:CAUSE_SW_LO] <= bus.data_i[CAUSE_SW_HI:CAUSE_SW_LO];
               end
               default: ;
            endcase
         end
      end
   end

   assign status_o = status;
   assign cause_o  = cause;
   assign epc_o    = epc;
   assign config_o = CONFIG_RESET;
   assign prid_o   = PRID_VALUE;

   // mfc0 read mux; forced to zero while reset is held
   always_comb begin
      bus.data_o = '0;
      if (rst) begin
         case (bus.raddr_i)
            CP0_REG_COUNT:   bus.data_o = count_o;
            CP0_REG_COMPARE: bus.data_o = compare_o;
            CP0_REG_STATUS:  bus.data_o = status;
            CP0_REG_CAUSE:   bus.data_o = cause;
            CP0_REG_EPC:     bus.data_o = epc;
            CP0_REG_PRID:    bus.data_o = PRID_VALUE;
            CP0_REG_CONFIG:  bus.data_o = CONFIG_RESET;
            default:         bus.data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed vectors for cp0_reg with hand-computed expectations.
// Timer checks follow whether CP0_TIMER_EN is defined for the build.
module tb_cp0_reg;

   logic        clk;
   logic        rst;
   logic [5:0]  int_i;
   logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
   logic        timer_int_o;

   int checks   = 0;
   int failures = 0;

   cp0_reg_if bus ();

   cp0_reg dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .int_i       (int_i),
      .count_o     (count_o),
      .compare_o   (compare_o),
      .status_o    (status_o),
      .cause_o     (cause_o),
      .epc_o       (epc_o),
      .config_o    (config_o),
      .prid_o      (prid_o),
      .timer_int_o (timer_int_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one-cycle mtc0
   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
      @(negedge clk);
      bus.we_i = 1'b0; bus.waddr_i = '0; bus.data_i = '0;
   endtask

   // one-cycle exception report, optionally with a colliding mtc0
   task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                      input logic we, input logic [4:0] a, input logic [31:0] d);
      bus.excepttype_i = code; bus.current_inst_addr_i = pc; bus.is_in_delayslot_i = ds;
      bus.we_i = we; bus.waddr_i = a; bus.data_i = d;
      @(negedge clk);
      bus.excepttype_i = '0; bus.current_inst_addr_i = '0; bus.is_in_delayslot_i = 1'b0;
      bus.we_i = 1'b0; bus.waddr_i = '0; bus.data_i = '0;
   endtask

   initial begin
      rst = 1'b0; int_i = '0;
      bus.we_i = 1'b0; bus.waddr_i = '0; bus.data_i = '0; bus.raddr_i = 5'd12;
      bus.excepttype_i = '0; bus.current_inst_addr_i = '0; bus.is_in_delayslot_i = 1'b0;

      // reset state
      cyc(2);
      chk("rst_data_o", bus.data_o, 32'h0);
      chk("rst_status", status_o, 32'h10000000);
      chk("rst_count", count_o, 32'h0);
      chk("rst_epc", epc_o, 32'h0);
      chk("rst_cause", cause_o, 32'h0);

      rst = 1'b1;
      cyc(10);
`ifdef CP0_TIMER_EN
      chk("cnt_10", count_o, 32'd10);
`else
      chk("cnt_10", count_o, 32'd0);
`endif
      chk("status_reset", status_o, 32'h10000000);
      chk("prid", prid_o, 32'h004c0102);
      chk("config", config_o, 32'h00008000);
      chk("timer_idle", {31'b0, timer_int_o}, 32'h0);

      // mfc0 reads
      bus.raddr_i = 5'd15; #1 chk("rd_prid", bus.data_o, 32'h004c0102);
      bus.raddr_i = 5'd16; #1 chk("rd_config", bus.data_o, 32'h00008000);
      bus.raddr_i = 5'd3;  #1 chk("rd_unk", bus.data_o, 32'h0);
      bus.raddr_i = 5'd12; #1 chk("rd_status", bus.data_o, 32'h10000000);

`ifdef CP0_TIMER_EN
      begin
         int n;
         mtc0(5'd9, 32'd5);
         chk("cnt_load", count_o, 32'd5);
         mtc0(5'd11, 32'd20);
         chk("cmp_load", compare_o, 32'd20);
         chk("tmr_pre", {31'b0, timer_int_o}, 32'h0);
         n = 0;
         while (!timer_int_o && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("tmr_rise", {31'b0, timer_int_o}, 32'h1);
         chk("tmr_rise_cnt", count_o, 32'd21);
         cyc(3);
         chk("tmr_hold", {31'b0, timer_int_o}, 32'h1);
         mtc0(5'd11, 32'd100);
         chk("tmr_clr", {31'b0, timer_int_o}, 32'h0);
         mtc0(5'd9, 32'hFFFFFFFF);
         chk("cnt_max", count_o, 32'hFFFFFFFF);
         cyc(1);
         chk("cnt_wrap", count_o, 32'h0);
         mtc0(5'd11, 32'd0);
      end
`else
      mtc0(5'd9, 32'hFFFFFFFF);
      chk("cnt_masked", count_o, 32'h0);
      mtc0(5'd11, 32'd1);
      chk("cmp_masked", compare_o, 32'h0);
      cyc(3);
      chk("tmr_off", {31'b0, timer_int_o}, 32'h0);
`endif

      // syscall in a delay slot, EXL=0
      exc(32'h8, 32'h100, 1'b1, 1'b0, 5'd0, 32'h0);
      chk("sys_epc", epc_o, 32'hFC);
      chk("sys_cause", cause_o, 32'h80000020);
      chk("sys_status", status_o, 32'h10000002);

      // nested overflow keeps EPC/BD
      exc(32'hc, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("ov_epc", epc_o, 32'hFC);
      chk("ov_cause", cause_o, 32'h80000030);

      // eret
      exc(32'he, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("eret_status", status_o, 32'h10000000);
      chk("eret_cause", cause_o, 32'h80000030);

      // interrupt wins over concurrent mtc0 EPC
      exc(32'h1, 32'h300, 1'b0, 1'b1, 5'd14, 32'hAAAA);
      chk("coll_epc", epc_o, 32'h300);
      chk("coll_cause", cause_o, 32'h0);
      chk("coll_status", status_o, 32'h10000002);
      exc(32'he, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

      // unknown code: no change, mtc0 dropped
      exc(32'h5, 32'h400, 1'b1, 1'b1, 5'd14, 32'h1234);
      chk("unk_epc", epc_o, 32'h300);
      chk("unk_status", status_o, 32'h10000000);

      // masked Cause write, then hardware IP sampling
      mtc0(5'd13, 32'hFFFFFFFF);
      chk("cause_mask", cause_o, 32'h00C00300);
      int_i = 6'b101010;
      cyc(1);
      bus.raddr_i = 5'd13; #1 chk("cause_ip", bus.data_o, 32'h00C0AB00);

      // plain writes and ignored registers
      mtc0(5'd12, 32'h0000_1234);
      chk("wr_status", status_o, 32'h00001234);
      mtc0(5'd14, 32'hDEAD_BEE0);
      chk("wr_epc", epc_o, 32'hDEADBEE0);
      mtc0(5'd16, 32'h0);
      mtc0(5'd15, 32'h0);
      chk("cfg_ro", config_o, 32'h00008000);
      chk("prid_ro", prid_o, 32'h004c0102);

      // async reset mid-operation discards a pending exception
      bus.excepttype_i = 32'h8; bus.current_inst_addr_i = 32'h500;
      bus.raddr_i = 5'd12;
      #2 rst = 1'b0;
      #1 chk("arst_status", status_o, 32'h10000000);
      chk("arst_data_o", bus.data_o, 32'h0);
      cyc(1);
      chk("arst_epc", epc_o, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the 5-stage MIPS32 core.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Records precise exceptions reported by the MEM stage, and raises the timer interrupt.
- Sits upstream of ctrl: epc_o drives ctrl's cp0_epc_i, which ctrl uses as the eret return target.

Parameters:
- PRID_VALUE, 32'h004c0102, read-only PRId contents.
- CONFIG_RESET, 32'h00008000, Config reset value (BE=1, big-endian).
- STATUS_RESET, 32'h10000000, Status reset value (CU0=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset. This polarity and synchronicity are fixed for this block; the global active-high RstEnable macro is not used here.
- we_i  in  1  mtc0 write enable, from the MEM/WB stage.
- waddr_i  in  5  CP0 register number to write.
- data_i  in  32  write data.
- raddr_i  in  5  CP0 register number read by mfc0.
- int_i  in  6  external hardware interrupt lines.
- excepttype_i  in  32  exception code from the MEM stage; same encoding ctrl consumes.
- current_inst_addr_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot.
- data_o  out  32  combinational read data for raddr_i.
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents.
- timer_int_o  out  1  sticky timer interrupt.

Behaviour:
- Reset, asynchronous, while rst==0: count=0, compare=0, status=STATUS_RESET, cause=0, epc=0, config=CONFIG_RESET, timer_int_o=0, data_o=0. prid_o always equals PRID_VALUE.
- Count: increments by 1 every cycle and wraps 32'hFFFFFFFF to 0. An mtc0 to Count (reg 9) loads data_i instead of incrementing.
- Timer interrupt: if compare!=0 and count==compare, timer_int_o is set at the next edge. It stays set until Compare (reg 11) is written. A Compare write in the same cycle as a match clears it; clear wins.
- Cause[15:10] samples int_i every cycle and is never software-writable.
- mtc0 writes, applied on the edge:
  - Status (12): full 32 bits.
  - Compare (11): full 32 bits.
  - EPC (14): full 32 bits.
  - Cause (13): only IP[9:8], WP[22] and IV[23].
  - Config, PRId and unknown addresses: ignored.
- Exception handling, applied on the same edge. Exceptions take priority over any mtc0 in the same cycle; the write is dropped entirely.
  - "Record" means: EPC = is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i, and Cause.BD[31] = is_in_delayslot_i.
  - 32'h1 interrupt: always record; Status.EXL[1]=1; Cause.ExcCode[6:2]=5'h00.
  - 32'h8 syscall, 32'ha invalid instruction, 32'hd trap, 32'hc overflow: record only when Status.EXL==0 (nested exceptions keep EPC/BD). Always set EXL=1. ExcCode = 5'h08, 5'h0a, 5'h0d, 5'h0c respectively.
  - 32'he eret: Status.EXL=0; no other change.
  - Any other non-zero code: no CP0 change.
- Read (data_o): muxed by raddr_i over regs 9, 11, 12, 13, 14, 15, 16. Other addresses return 0. No write-through bypass; forwarding is the EX stage's job.
- Reset asserted mid-operation discards any pending exception or write.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count/Compare/timer_int_o behave as above.
- Undefined: count_o and compare_o read 0, writes to regs 9 and 11 are ignored, timer_int_o is tied 0, and no counter flops are inferred.

Decomposition:
- Add to the shared defines.v:
  - CP0 register numbers: CP0_REG_COUNT 5'd9, CP0_REG_COMPARE 5'd11, CP0_REG_STATUS 5'd12, CP0_REG_CAUSE 5'd13, CP0_REG_EPC 5'd14, CP0_REG_PRID 5'd15, CP0_REG_CONFIG 5'd16.
  - Exception-type codes shared with ctrl: EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV, EXC_ERET.
  - Status/Cause bit-position constants.
- One sub-module, cp0_timer, holding Count, Compare, timer_int and the wrap/clear logic; it is removed entirely when CP0_TIMER_EN is off.

Test Plan:
- Reset: release rst, run 10 cycles, no writes -> count_o==10, status_o==32'h10000000, prid_o==32'h004c0102, timer_int_o==0.
- Timer: mtc0 Compare=20 with count at 5 -> timer_int_o rises the cycle after count==20 and holds; mtc0 Compare=100 -> timer_int_o==0 next cycle.
- Syscall in a delay slot: excepttype 32'h8, PC 32'h100, delayslot=1, EXL=0 -> epc_o==32'hFC, cause_o[31]==1, cause_o[6:2]==5'h08, status_o[1]==1.
- Nested overflow: with EXL=1 raise 32'hc at PC 32'h200 -> EPC unchanged, ExcCode==5'h0c. Then eret 32'he -> status_o[1]==0.
- Collision: mtc0 EPC=32'hAAAA in the same cycle as interrupt 32'h1 at PC 32'h300, delayslot=0 -> epc_o==32'h300. Separately, mtc0 Cause=32'hFFFFFFFF -> only bits 23, 22, 9, 8 set.
- Wrap and masked writes: mtc0 Count=32'hFFFFFFFF -> next cycle count_o==0. With CP0_TIMER_EN undefined -> count_o stays 0 and timer_int_o stays 0.
